uart_rx: RTL

UART serial receiver: the stage directly downstream of the team's UART transmitter, consuming the `tx` line it drives.
- Oversamples `rx` at 16× the baud rate using a clock-enable tick; the whole block runs on the single system clock, with no derived clocks.
- Recovers 8N1 frames, LSB first, and presents each byte with a one-cycle `donerx` strobe plus a frame-error flag.
- Sits between the serial pin and the byte-level consumer logic.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_rx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state type, oversampling ratio and baud divider helper.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Clocks per oversample tick; integer truncation, shared with the transmitter.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / (baud_rate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick every Div clocks.
module uart_baud_tick #(
  parameter int unsigned Div = 6
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  if (Div == 0) begin : gen_div_check
    $error("uart_baud_tick: divider must be at least 1");
  end

  logic [CntW-1:0] cnt_q;

  assign tick_o = (cnt_q == CntMax);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; optional even parity via UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       donerx,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned Div = calc_div(clk_freq, baud_rate);

  logic tick;

  uart_baud_tick #(
    .Div(Div)
  ) u_baud_tick (
    .clk_i (clk),
    .rst_i (rst),
    .tick_o(tick)
  );

  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  uart_state_e state_q;
  logic [3:0]  sample_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  rx_data_q;
  logic        armed_q, donerx_q, frame_err_q, busy_q;
`ifdef UART_RX_PARITY_EN
  logic        par_pend_q, parity_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      armed_q      <= 1'b0;
      donerx_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend_q   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      donerx_q <= 1'b0;
      if (tick) begin
        case (state_q)
          StIdle: begin
            if (rx_sync_q) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q      <= StStart;
              sample_cnt_q <= '0;
              busy_q       <= 1'b1;
            end
          end
          StStart: begin
            sample_cnt_q <= sample_cnt_q + 4'd1;
            if (sample_cnt_q == 4'd7) begin
              sample_cnt_q <= '0;
              if (rx_sync_q) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end else begin
                state_q   <= StData;
                bit_cnt_q <= '0;
              end
            end
          end
          StData: begin
            // 4-bit counter wraps at 16, giving one sample per bit period.
            sample_cnt_q <= sample_cnt_q + 4'd1;
            if (sample_cnt_q == 4'd15) begin
              shift_q   <= {rx_sync_q, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= StParity;
`else
                state_q <= StStop;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          StParity: begin
            sample_cnt_q <= sample_cnt_q + 4'd1;
            if (sample_cnt_q == 4'd15) begin
              par_pend_q <= (^shift_q) ^ rx_sync_q;
              state_q    <= StStop;
            end
          end
`endif
          StStop: begin
            sample_cnt_q <= sample_cnt_q + 4'd1;
            if (sample_cnt_q == 4'd15) begin
              rx_data_q   <= shift_q;
              donerx_q    <= 1'b1;
              frame_err_q <= ~rx_sync_q;
              // A low stop bit (break) disarms detection until the line idles high.
              armed_q     <= rx_sync_q;
              busy_q      <= 1'b0;
              state_q     <= StIdle;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_pend_q;
`endif
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign donerx    = donerx_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
